trig_ts_fifo: RTL and testbench

- Parametrised multi-channel trigger timestamp capture with an internal first-word-fall-through FIFO and a register slave on a simple pipelined Wishbone-style bus.
- Successor to the fixed 4-channel trigger-out register block: channel count and FIFO depth are now parameters.
- Adds on-chip buffering, overflow accounting, a flush command and a count readback.
- Sits between the ADC trigger logic (`trig_i` / `ext_trig_i`) and the WR timebase; host software drains events over the bus.

---
 rtl/trig_ts_fifo.sv | 155 +++++++++++++++
 tb/tb_trig_ts_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/trig_ts_fifo.sv
// Trigger timestamp capture into a FWFT FIFO, drained via a pipelined bus slave.
// Entry visible 1 cycle after trigger; bus ack 2 cycles after request, stalls while a transfer is in flight.
module trig_ts_fifo #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_stall_o,
  input  logic [NCH-1:0]   trig_i,
  input  logic             ext_trig_i,
  input  logic [39:0]      tai_i,
  input  logic [27:0]      cycles_i,
  input  logic             wr_valid_i,
  output logic [NCH-1:0]   ch_enable_o,
  output logic             ext_enable_o,
  output logic             fifo_empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [8:0]  mask;
    logic [39:0] sec;
    logic [27:0] cyc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full;
  logic [NCH-1:0]  ch_enable;
  logic            ext_enable, require_valid;
  logic            ovf;
  logic [15:0]     ovf_cnt;

  logic            pend, pop_q, req, req_we;
  logic [2:0]      req_adr;
  logic [31:0]     req_dat, rdata, status, ctrl_rb;
  logic            wr_ctrl, flush, push_req, pop, do_push, drop;
  logic [8:0]      mask;
  logic            unused_bits;

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign head         = mem[rd_ptr[AW-1:0]];
  assign ch_enable_o  = ch_enable;
  assign ext_enable_o = ext_enable;
  assign fifo_empty_o = empty;
  assign unused_bits  = ^req_dat;

  // A new request is only taken once the previous one has fully acked.
  assign req        = wb_cyc_i & wb_stb_i & ~pend & ~wb_ack_o;
  assign wb_stall_o = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  assign wr_ctrl  = pend & req_we & (req_adr == 3'd1);
  assign flush    = wr_ctrl & req_dat[31];

  always_comb begin
    mask = '0;
    mask[NCH-1:0] = trig_i & ch_enable;
    mask[8] = ext_trig_i & ext_enable;
  end

  assign push_req = (|mask) & (~require_valid | wr_valid_i) & ~flush;
  assign pop      = pop_q & ~empty;
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    status = '0;
    status[0] = wr_valid_i;
    status[1] = empty;
    status[2] = full;
    status[3] = ovf;
    status[16 +: CW] = count;
    ctrl_rb = '0;
    ctrl_rb[NCH-1:0] = ch_enable;
    ctrl_rb[8] = ext_enable;
    ctrl_rb[30] = require_valid;
    rdata = '0;
    case (req_adr)
      3'd0: rdata = status;
      3'd1: rdata = ctrl_rb;
      3'd2: rdata = empty ? '0 : {7'b0, head.mask, 8'b0, head.sec[39:32]};
      3'd3: rdata = empty ? '0 : head.sec[31:0];
      3'd4: rdata = empty ? '0 : {4'b0, head.cyc};
      3'd5: rdata = {16'b0, ovf_cnt};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= '{mask: mask, sec: tai_i, cyc: cycles_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend          <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= '0;
      pop_q         <= 1'b0;
      req_we        <= 1'b0;
      req_adr       <= '0;
      req_dat       <= '0;
      ch_enable     <= '0;
      ext_enable    <= 1'b0;
      require_valid <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ovf           <= 1'b0;
      ovf_cnt       <= '0;
    end else begin
      pend     <= req;
      wb_ack_o <= pend;
      if (req) begin
        req_we  <= wb_we_i;
        req_adr <= wb_adr_i;
        req_dat <= wb_dat_i;
      end
      // Pop lands in the ack cycle, after the head has been latched into wb_dat_o.
      pop_q    <= pend & ~req_we & (req_adr == 3'd4) & ~empty;
      wb_dat_o <= (pend & ~req_we) ? rdata : '0;
      if (wr_ctrl) begin
        ch_enable     <= req_dat[NCH-1:0];
        ext_enable    <= req_dat[8];
        require_valid <= req_dat[30];
      end
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ovf     <= 1'b0;
        ovf_cnt <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (drop) begin
          ovf <= 1'b1;
          if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trig_ts_fifo.sv
// Directed bench for trig_ts_fifo: capture, enables, overflow, full push+pop, require_valid, flush, bus corners.
module tb_trig_ts_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, wb_stall_o;
  logic [3:0]  trig_i;
  logic        ext_trig_i;
  logic [39:0] tai_i;
  logic [27:0] cycles_i;
  logic        wr_valid_i;
  logic [3:0]  ch_enable_o;
  logic        ext_enable_o, fifo_empty_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] r;

  trig_ts_fifo #(.NCH(4), .DEPTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .trig_i(trig_i), .ext_trig_i(ext_trig_i), .tai_i(tai_i), .cycles_i(cycles_i),
    .wr_valid_i(wr_valid_i), .ch_enable_o(ch_enable_o), .ext_enable_o(ext_enable_o),
    .fifo_empty_o(fifo_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transfer; tat selects the cycle after the request (1 or 2) in which tv drives trig_i.
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input int tat, input logic [3:0] tv, output logic [31:0] rd);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_adr_i = a; wb_dat_i = d;
    while (!got && n < 8) begin
      @(posedge clk_i); #1;
      n++;
      trig_i = (n == tat) ? tv : 4'b0;
      if (wb_ack_o) got = 1'b1;
    end
    chk("ack_latency", 32'(n), 32'd2);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_i); #1;
    trig_i = 4'b0;
    chk("ack_single_cycle", {31'b0, wb_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, 0, 4'b0, dummy);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    bus(1'b0, a, 32'b0, 0, 4'b0, v);
  endtask

  task automatic pulse(input logic [3:0] t, input logic e, input logic [39:0] s, input logic [27:0] c);
    trig_i = t; ext_trig_i = e; tai_i = s; cycles_i = c;
    @(posedge clk_i); #1;
    trig_i = 4'b0; ext_trig_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
    trig_i = '0; ext_trig_i = 0; tai_i = '0; cycles_i = '0; wr_valid_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_empty", {31'b0, fifo_empty_o}, 32'd1);
    chk("rst_ch_en", {28'b0, ch_enable_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rd(3'd0, r); chk("rst_status", r, 32'h0000_0002);

    // Basic capture with two channels
    wr(3'd1, 32'h0000_0105);
    chk("ch_en_out", {28'b0, ch_enable_o}, 32'h5);
    chk("ext_en_out", {31'b0, ext_enable_o}, 32'h1);
    pulse(4'b0101, 1'b0, 40'h12_3456_789A, 28'h0ABCDEF);
    rd(3'd0, r); chk("t1_status", r, 32'h0001_0000);
    rd(3'd2, r); chk("t1_mask_sec", r, 32'h0005_0012);
    rd(3'd3, r); chk("t1_sec", r, 32'h3456_789A);
    rd(3'd4, r); chk("t1_cycles", r, 32'h00AB_CDEF);
    rd(3'd0, r); chk("t1_status_empty", r, 32'h0000_0002);
    chk("t1_empty_out", {31'b0, fifo_empty_o}, 32'd1);

    // Disabled channel ignored, then enabled
    wr(3'd1, 32'h0000_0001);
    pulse(4'b0010, 1'b0, 40'hAB_0000_0000, 28'h1);
    rd(3'd0, r); chk("t2_masked", r, 32'h0000_0002);
    wr(3'd1, 32'h0000_0003);
    pulse(4'b0010, 1'b0, 40'hAB_0000_0000, 28'h1);
    rd(3'd0, r); chk("t2_count1", r, 32'h0001_0000);
    rd(3'd2, r); chk("t2_mask_sec", r, 32'h0002_00AB);
    rd(3'd4, r); chk("t2_pop", r, 32'h0000_0001);

    // Overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) pulse(4'b0001, 1'b0, 40'(i), 28'(i + 1));
    rd(3'd0, r); chk("t3_status_full", r, 32'h0010_000C);
    rd(3'd5, r); chk("t3_ovf_cnt", r, 32'd4);
    for (int i = 0; i < 16; i++) begin
      rd(3'd4, r); chk("t3_drain", r, 32'(i + 1));
    end
    rd(3'd4, r); chk("t3_underflow_read", r, 32'd0);
    rd(3'd0, r); chk("t3_status_after", r, 32'h0000_000A);

    // Full FIFO: trigger coincides with popping read's ack
    for (int i = 0; i < 16; i++) pulse(4'b0001, 1'b0, 40'h0, 28'(32'h100 + i));
    cycles_i = 28'h200;
    bus(1'b0, 3'd4, 32'b0, 2, 4'b0001, r);
    chk("t4_read_head", r, 32'h100);
    rd(3'd0, r); chk("t4_status", r, 32'h0010_000C);
    rd(3'd5, r); chk("t4_ovf_cnt", r, 32'd4);
    for (int i = 1; i < 16; i++) begin
      rd(3'd4, r); chk("t4_drain", r, 32'(32'h100 + i));
    end
    rd(3'd4, r); chk("t4_tail", r, 32'h200);

    // require_valid gating
    wr(3'd1, 32'h4000_0001);
    pulse(4'b0001, 1'b0, 40'h0, 28'h111);
    rd(3'd0, r); chk("t5_dropped", r, 32'h0000_000A);
    rd(3'd5, r); chk("t5_ovf_cnt", r, 32'd4);
    wr_valid_i = 1'b1;
    pulse(4'b0001, 1'b0, 40'h0, 28'h333);
    rd(3'd0, r); chk("t5_stored", r, 32'h0001_0009);
    rd(3'd1, r); chk("t5_ctrl", r, 32'h4000_0001);

    // Flush with a simultaneous trigger
    pulse(4'b0001, 1'b0, 40'h0, 28'h334);
    pulse(4'b0001, 1'b0, 40'h0, 28'h335);
    rd(3'd0, r); chk("t6_pre", r, 32'h0003_0009);
    bus(1'b1, 3'd1, 32'h8000_0001, 1, 4'b0001, r);
    rd(3'd0, r); chk("t6_status", r, 32'h0000_0003);
    rd(3'd5, r); chk("t6_ovf_cnt", r, 32'd0);
    rd(3'd1, r); chk("t6_ctrl", r, 32'h0000_0001);
    chk("t6_empty_out", {31'b0, fifo_empty_o}, 32'd1);

    // Undefined addresses
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, r); chk("undef_rd6", r, 32'd0);
    rd(3'd7, r); chk("undef_rd7", r, 32'd0);
    rd(3'd1, r); chk("undef_ctrl_kept", r, 32'h0000_0001);

    // Reset while a transfer is pending
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 3'd0;
    @(posedge clk_i); #1;
    rst_i = 1'b1; wb_cyc_i = 0; wb_stb_i = 0;
    @(posedge clk_i); #1;
    chk("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_ack2", {31'b0, wb_ack_o}, 32'd0);
    rd(3'd1, r); chk("midrst_ctrl", r, 32'd0);
    rd(3'd0, r); chk("midrst_status", r, 32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
